// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair: capture FSM state
// type, default counter width and the generator period used by loopback benches.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_e;

    localparam int PWM_CNT_W  = 16;
    localparam int PWM_PERIOD = 20;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for pwm_capture: synchronizer, optional stability filter
// (compiled in with PWM_CAP_GLITCH_FILTER_EN), one-clock delayed level and
// rise/fall detection. `level` is the delayed accepted level, so it moves on
// the same clock as the measurement strobe.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_s;
    logic                   s_d_r;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    logic       filt_r;
    logic [3:0] run_r;
    logic       accept_s;

    // A new level is accepted on its FILT_LEN-th consecutive sample; the
    // accepting sample passes straight through so the added delay is FILT_LEN-1.
    always_comb begin
        accept_s = (sync_r[SYNC_STAGES-1] != filt_r) && (run_r == RUN_LAST);
        if (accept_s) begin
            s_s = sync_r[SYNC_STAGES-1];
        end else begin
            s_s = filt_r;
        end
    end

    // Count consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_r <= 1'b0;
            run_r  <= 4'd0;
        end else if (sync_r[SYNC_STAGES-1] == filt_r) begin
            run_r  <= 4'd0;
        end else if (accept_s) begin
            filt_r <= sync_r[SYNC_STAGES-1];
            run_r  <= 4'd0;
        end else begin
            run_r  <= run_r + 4'd1;
        end
    end
`else
    assign s_s = sync_r[SYNC_STAGES-1];
`endif

    // One-clock delayed copy of the accepted level for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_d_r <= 1'b0;
        end else begin
            s_d_r <= s_s;
        end
    end

    assign level = s_d_r;
    assign rise  = s_s & ~s_d_r;
    assign fall  = ~s_s & s_d_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of each complete cycle of an
// asynchronous PWM input and publishes them with a one-cycle strobe.
// Optional glitch filter: define PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] ton_out,
    output logic [CNT_W-1:0] period_out,
    output logic             meas_valid,
    output logic             stuck,
    output logic             level
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pwm_capture: SYNC_STAGES must be at least 2");
    end
    if ((FILT_LEN < 2) || (FILT_LEN > 15)) begin : g_bad_filt
        $error("pwm_capture: FILT_LEN must be within 2..15");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    cap_state_e       state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic [CNT_W-1:0] ton_cap_r, ton_cap_nx;
    logic [CNT_W-1:0] ton_nx, period_nx;
    logic             valid_nx, stuck_nx;
    logic             rise_s, fall_s;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // Next-state, counter and publish logic. A fall arriving exactly at the
    // counter ceiling is treated as a timeout: the period could not be
    // represented without wrapping.
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        ton_cap_nx = ton_cap_r;
        ton_nx     = ton_out;
        period_nx  = period_out;
        valid_nx   = 1'b0;
        stuck_nx   = stuck;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nx = ST_HIGH;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx   = CNT_ZERO;
                end
            end
            ST_HIGH: begin
                if (cnt_r == CNT_MAX) begin
                    state_nx = ST_IDLE;
                    stuck_nx = 1'b1;
                end else if (fall_s) begin
                    state_nx   = ST_LOW;
                    ton_cap_nx = cnt_r;
                    cnt_nx     = cnt_r + CNT_ONE;
                end else begin
                    cnt_nx     = cnt_r + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    state_nx  = ST_HIGH;
                    period_nx = cnt_r;
                    ton_nx    = ton_cap_r;
                    valid_nx  = 1'b1;
                    stuck_nx  = 1'b0;
                    cnt_nx    = CNT_ONE;
                end else if (cnt_r == CNT_MAX) begin
                    state_nx = ST_IDLE;
                    stuck_nx = 1'b1;
                end else begin
                    cnt_nx   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = CNT_ZERO;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            ton_cap_r  <= CNT_ZERO;
            ton_out    <= CNT_ZERO;
            period_out <= CNT_ZERO;
            meas_valid <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state_r    <= state_nx;
            cnt_r      <= cnt_nx;
            ton_cap_r  <= ton_cap_nx;
            ton_out    <= ton_nx;
            period_out <= period_nx;
            meas_valid <= valid_nx;
            stuck      <= stuck_nx;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. Input is driven on the falling edge;
// a timestamp-based reference model predicts every output, delayed by the
// synchronizer latency through a queue.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int MAXV        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] ton_out;
    logic [CNT_W-1:0] period_out;
    logic             meas_valid;
    logic             stuck;
    logic             level;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .ton_out    (ton_out),
        .period_out (period_out),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ton;
        int period;
        bit valid;
        bit stuck;
        bit level;
    } exp_t;

    exp_t  q[$];
    exp_t  cur;
    int    n_assert = 0;
    int    n_fail   = 0;
    int    n_strobe = 0;
    int    last_ton = 0;
    int    last_per = 0;
    string phase    = "init";

    // reference model state
    bit acc, prev_a;
    int run, t, r, f;
    bit armed;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s [%s]: observed %0d expected %0d", tag, phase, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        z = '{ton: 0, period: 0, valid: 1'b0, stuck: 1'b0, level: 1'b0};
        q.delete();
        repeat (LAT - 1) q.push_back(z);
        cur = z;
        acc = 1'b0; prev_a = 1'b0; run = 0;
        armed = 1'b0; t = 0; r = 0; f = 0;
    endtask

    // Measurement from rise/fall timestamps of the accepted level.
    task automatic model_push(input bit x);
        bit a, rs, fl;
        t++;
`ifdef PWM_CAP_GLITCH_FILTER_EN
        if (x == acc) run = 0;
        else begin
            run++;
            if (run >= FILT_LEN) begin
                acc = x;
                run = 0;
            end
        end
        a = acc;
`else
        a = x;
`endif
        rs = a && !prev_a;
        fl = !a && prev_a;
        prev_a = a;
        cur.valid = 1'b0;
        if (!armed) begin
            if (rs) begin
                armed = 1'b1;
                r = t;
            end
        end else if (rs) begin
            cur.ton    = f - r;
            cur.period = t - r;
            cur.valid  = 1'b1;
            cur.stuck  = 1'b0;
            r = t;
        end else if (t - r >= MAXV) begin
            armed = 1'b0;
            cur.stuck = 1'b1;
        end else if (fl) begin
            f = t;
        end
        cur.level = a;
        q.push_back(cur);
    endtask

    task automatic step(input bit x);
        exp_t e;
        @(negedge clk);
        e = q.pop_front();
        chk("level",      32'(level),      32'(e.level));
        chk("meas_valid", 32'(meas_valid), 32'(e.valid));
        chk("stuck",      32'(stuck),      32'(e.stuck));
        chk("ton_out",    32'(ton_out),    e.ton);
        chk("period_out", 32'(period_out), e.period);
        if (meas_valid === 1'b1) begin
            n_strobe++;
            last_ton = int'(ton_out);
            last_per = int'(period_out);
            chk("inv_ton_ge1",     32'(ton_out >= 16'd1),        32'd1);
            chk("inv_ton_lt_per",  32'(ton_out < period_out),    32'd1);
            chk("inv_period_ge2",  32'(period_out >= 16'd2),     32'd1);
        end
        pwm_in = x;
        model_push(x);
    endtask

    task automatic run_phase(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic apply_reset(input bit x);
        @(negedge clk);
        rst = 1'b0;
        pwm_in = x;
        #1;
        chk("rst_ton",    32'(ton_out),    32'd0);
        chk("rst_period", 32'(period_out), 32'd0);
        chk("rst_valid",  32'(meas_valid), 32'd0);
        chk("rst_stuck",  32'(stuck),      32'd0);
        chk("rst_level",  32'(level),      32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        model_push(x);
    endtask

    initial begin
        int s0;
        int duties[5];
        duties = '{1, 6, 11, 16, 21};

        phase = "reset";
        apply_reset(1'b0);

        phase = "clean_5_15";
        s0 = n_strobe;
        repeat (4) run_phase(5, 15);
        chk("clean_strobes", 32'(n_strobe - s0), 32'd3);
        chk("clean_ton",     32'(last_ton),      32'd5);
        chk("clean_period",  32'(last_per),      32'd20);

        phase = "loopback";
        foreach (duties[i]) begin
            if (duties[i] < PWM_PERIOD) begin
                repeat (2) run_phase(duties[i], PWM_PERIOD - duties[i]);
                chk("loop_ton",    32'(last_ton), 32'(duties[i]));
                chk("loop_period", 32'(last_per), 32'(PWM_PERIOD));
            end
        end

        phase = "toggle_1_1";
        repeat (10) run_phase(1, 1);
`ifndef PWM_CAP_GLITCH_FILTER_EN
        chk("toggle_ton",    32'(last_ton), 32'd1);
        chk("toggle_period", 32'(last_per), 32'd2);
`endif

        phase = "random";
        repeat (30) run_phase(int'($urandom_range(1, 25)), int'($urandom_range(1, 25)));

        phase = "reset_mid_high";
        run_phase(6, 0);
        apply_reset(1'b1);
        s0 = n_strobe;
        run_phase(4, 10);
        run_phase(7, 13);
        run_phase(1, 5);
        chk("rst_strobes", 32'(n_strobe - s0), 32'd2);
        chk("rst_ton2",    32'(last_ton),      32'd7);
        chk("rst_period2", 32'(last_per),      32'd20);

        phase = "stuck_high";
        run_phase(0, 20);
        run_phase(10, 0);
        s0 = n_strobe;
        run_phase(65530, 0);
        chk("stuck_no_strobe", 32'(n_strobe - s0), 32'd0);
        chk("stuck_flag",      32'(stuck),         32'd1);
        chk("stuck_level",     32'(level),         32'd1);
        run_phase(0, 15);
        run_phase(5, 15);
        run_phase(1, 5);
        chk("stuck_cleared", 32'(stuck),    32'd0);
        chk("stuck_ton",     32'(last_ton), 32'd5);
        chk("stuck_period",  32'(last_per), 32'd20);

`ifdef PWM_CAP_GLITCH_FILTER_EN
        phase = "glitch";
        repeat (3) begin
            run_phase(4, 1);
            run_phase(5, 10);
        end
        run_phase(1, 5);
        chk("glitch_ton",    32'(last_ton), 32'd10);
        chk("glitch_period", 32'(last_per), 32'd20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
